// File: rtl/ps2_keystroke_pkg.sv
// Shared constants for the PS/2 keyboard to game-command decoder.
// Latency: n/a (constants, types and a parity helper only).
// Backpressure: n/a.
package ps2_keystroke_pkg;

  // Prefix codes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Player 1 keys (no extended prefix)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Player 2 arrow keys (only valid after SC_EXT)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Game control keys (no extended prefix)
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_MINUS = 8'h4E;
  localparam logic [7:0] SC_EQUAL = 8'h55;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Bit positions inside the keystroke vector
  localparam int KS_P1_UP    = 0;
  localparam int KS_P1_DOWN  = 1;
  localparam int KS_P1_LEFT  = 2;
  localparam int KS_P1_RIGHT = 3;
  localparam int KS_P2_UP    = 4;
  localparam int KS_P2_DOWN  = 5;
  localparam int KS_P2_LEFT  = 6;
  localparam int KS_P2_RIGHT = 7;
  localparam int KS_RESET    = 8;
  localparam int KS_PAUSE    = 9;
  localparam int KS_SLOWER   = 10;
  localparam int KS_FASTER   = 11;
  localparam int KS_RUN      = 12;
  localparam int KS_W        = 13;

  // Receiver frame FSM encoding
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // PS/2 uses odd parity over data + parity bit
  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, 11-bit frame FSM, odd-parity check, idle timeout.
// Latency: byte_valid / frame_err pulse 1 clk after the stop-bit falling edge is detected.
// Backpressure: none; the keyboard cannot be stalled, every accepted byte is a single pulse.
module ps2_rx
  import ps2_keystroke_pkg::*;
#(
  parameter int clk_freq   = 100_000_000,
  parameter int timeout_us = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  // 64-bit product: 500 us * 100 MHz does not fit in 32 bits
  localparam longint TO_PROD   = longint'(timeout_us) * longint'(clk_freq);
  localparam int     TO_CYCLES = int'(TO_PROD / 64'sd1_000_000);
  localparam int     TO_W      = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);

  logic            clk_s1, clk_s2, clk_q;
  logic            dat_s1, dat_s2;
  logic            fall;
  rx_state_t       state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            accept, reject;

  // Two-flop synchronizers plus a delayed copy of ps2_clk for edge detection; idle level is 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_q & ~clk_s2;

  // A falling edge always restarts the timeout, so a timeout and an edge never coincide
  assign timeout_hit = (state != RX_IDLE) && !fall && (to_cnt == '0);

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; the stop-bit edge decides accept or reject
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    if (timeout_hit) begin
      state_nxt = RX_IDLE;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!dat_s2) state_nxt = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        RX_PARITY: state_nxt = RX_STOP;
        RX_STOP: begin
          state_nxt = RX_IDLE;
          if (dat_s2 && odd_ones({par_bit, shift})) accept = 1'b1;
          else                                      reject = 1'b1;
        end
        default:   state_nxt = RX_IDLE;
      endcase
    end
  end

  // Shift register, bit counter and parity capture; data arrives LSB first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (fall && !timeout_hit) begin
      case (state)
        RX_IDLE:   bit_cnt <= '0;
        RX_DATA: begin
          shift   <= {dat_s2, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        RX_PARITY: par_bit <= dat_s2;
        default:   ;
      endcase
    end
  end

  // Idle-gap counter: reloaded on each edge, counts down while a frame is open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                to_cnt <= '0;
    else if (fall)           to_cnt <= TO_W'(TO_CYCLES);
    else if (to_cnt != '0)   to_cnt <= to_cnt - 1'b1;
  end

  // Registered one-cycle result pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= accept;
      frame_err  <= reject;
    end
  end

  // Shift register is stable from the stop bit until the next start bit
  assign rx_byte = shift;

endmodule

// File: rtl/ps2_keystroke.sv
// PS/2 keyboard to 13-bit game command vector (player moves, reset, pause, speed, run).
// Latency: keystroke updates 1 clk after byte_valid, 2 clk after the stop-bit edge is detected.
// Backpressure: none; the game core samples keystroke every cycle, pulses last exactly 1 clk.
module ps2_keystroke
  import ps2_keystroke_pkg::*;
#(
  parameter int clk_freq   = 100_000_000,
  parameter int timeout_us = 500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [KS_W-1:0] keystroke,
  output logic            frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;
  logic       ext, brk, p_held;
  logic       make;

  ps2_rx #(
    .clk_freq   (clk_freq),
    .timeout_us (timeout_us)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (rx_vld),
    .frame_err  (rx_err)
  );

  assign frame_err = rx_err;
  assign make      = ~brk;

  // Prefix tracking and keystroke register update on each received byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keystroke <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      p_held    <= 1'b0;
    end else begin
      // Rate and reset bits are strictly one-cycle pulses
      keystroke[KS_RESET]  <= 1'b0;
      keystroke[KS_SLOWER] <= 1'b0;
      keystroke[KS_FASTER] <= 1'b0;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_vld) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (ext) begin
            case (rx_byte)
              SC_UP:    keystroke[KS_P2_UP]    <= make;
              SC_DOWN:  keystroke[KS_P2_DOWN]  <= make;
              SC_LEFT:  keystroke[KS_P2_LEFT]  <= make;
              SC_RIGHT: keystroke[KS_P2_RIGHT] <= make;
              default:  ;
            endcase
          end else begin
            case (rx_byte)
              SC_W:     keystroke[KS_P1_UP]    <= make;
              SC_S:     keystroke[KS_P1_DOWN]  <= make;
              SC_A:     keystroke[KS_P1_LEFT]  <= make;
              SC_D:     keystroke[KS_P1_RIGHT] <= make;
              SC_R: begin
                if (make) begin
                  keystroke[KS_RESET] <= 1'b1;
                  keystroke[KS_PAUSE] <= 1'b0;
                  keystroke[KS_RUN]   <= 1'b0;
                end
              end
              SC_P: begin
                // Typematic repeats arrive while p_held is set and must not toggle
                if (make && !p_held) keystroke[KS_PAUSE] <= ~keystroke[KS_PAUSE];
                p_held <= make;
              end
              SC_MINUS: if (make) keystroke[KS_SLOWER] <= 1'b1;
              SC_EQUAL: if (make) keystroke[KS_FASTER] <= 1'b1;
              SC_ENTER: if (make) keystroke[KS_RUN]    <= 1'b1;
              default:  ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_keystroke.md
PS2_KEYSTROKE -- requirements
Module: ps2_keystroke

Interface
REQ-001 Parameter clk_freq, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter timeout_us, default 500, longest idle gap inside one PS/2 frame before the partial frame is discarded.
REQ-003 clk  input  1  system clock; the design has a single clock domain, and everything is registered on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 keystroke  output  13  game command vector driven to the game core, with bit meanings fixed by REQ-015 to REQ-020.
REQ-008 frame_err  output  1  one-cycle pulse raised on a parity, start-bit or stop-bit error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected when the synchronized ps2_clk value moves from 1 to 0.
REQ-010 Receiver FSM states and transitions SHALL be:
- IDLE -> DATA on a falling edge with data=0 (start bit); a falling edge with data=1 is ignored.
- DATA shifts in 8 bits, LSB first, then moves to PARITY.
- PARITY -> STOP.
- STOP -> IDLE.
REQ-011 Frame acceptance in STOP SHALL be:
- The frame is accepted only if the stop bit is 1 and the 9 bits (8 data + parity) hold an odd number of ones.
- An accepted frame raises a one-cycle byte_valid exactly 1 clk after the stop-bit edge is detected.
- A rejected frame raises a one-cycle frame_err in that same cycle instead.
REQ-012 Timeout: a counter of timeout_us*clk_freq/1e6 cycles SHALL be reloaded on every falling edge; if it expires in any non-IDLE state, the FSM returns to IDLE with no byte_valid and no frame_err.
REQ-013 The decoder SHALL handle prefix codes and errors as follows:
- Byte 0xE0 sets the ext flag.
- Byte 0xF0 sets the brk flag.
- Any other byte is decoded as a key using ext/brk, and then both flags clear.
- frame_err also clears both flags.
REQ-014 Key map (ext=0 unless noted), where "make" means the key is pressed and "break" means it is released:
- W=0x1D, S=0x1B, A=0x1C, D=0x23.
- Arrow keys (ext=1): up=0x75, down=0x72, left=0x6B, right=0x74.
- R=0x2D, P=0x4D, minus=0x4E, equals=0x55, Enter=0x5A.
REQ-015 keystroke[3:0] = up, down, left, right for player 1 (W, S, A, D); each bit is level-held, set on make and cleared on break.
REQ-016 keystroke[7:4] = up, down, left, right for player 2 (arrow keys); each bit is level-held and requires ext=1.
- The same base code with ext=0 SHALL NOT affect these bits.
- Typematic repeat makes SHALL leave a held bit at 1.
REQ-017 keystroke[8] = game reset: a one-cycle pulse on make of R, and nothing on break.
REQ-018 keystroke[9] = pause: toggles on each make of P, and is ignored on break and during typematic repeat.
- Repeat is detected as a make of P while the internal P-held flag is already set.
REQ-019 keystroke[10] = slower, a one-cycle pulse on make of minus; keystroke[11] = faster, a one-cycle pulse on make of equals.
- Each repeat make SHALL produce one further pulse.
- Pulses SHALL never be longer than 1 cycle, because the core adds 1 to or subtracts 1 from its rate on every cycle the bit is high.
REQ-020 keystroke[12] = run enable:
- Set on make of Enter.
- Cleared, together with keystroke[9], on make of R.
- Held otherwise.
REQ-021 Unmapped codes SHALL be consumed without changing keystroke.
REQ-022 Latency: keystroke SHALL change exactly 1 cycle after byte_valid, which is 2 cycles after the stop-bit edge is detected.
REQ-023 If byte_valid and a timeout occur in the same cycle, the byte SHALL be decoded.

Reset
REQ-024 While rst=0, the following SHALL hold, asynchronously:
- keystroke = 13'b0 and frame_err = 0.
- The FSM is in IDLE, the bit counter and shift register are 0, the ext, brk and held flags are 0, and the timeout counter is cleared.
- The synchronizer flops are set to 1, which is the PS/2 idle level.
REQ-025 If rst is asserted mid-frame, the partial frame SHALL be dropped; after release, decoding resumes at the next start bit.

Structure
REQ-026 A shared package SHALL hold:
- The scan-code constants.
- The keystroke bit-index constants (KS_P1_UP through KS_RUN).
- The receiver FSM state encoding.
REQ-027 A single sub-module, ps2_rx, SHALL contain the synchronizer, frame FSM, parity check and timeout, and output byte[7:0], byte_valid and frame_err.
REQ-028 The top level SHALL contain only the ext/brk/held decoding and the keystroke registers.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Frames 0x1D, then F0 1D -> keystroke[0]=1 after the first frame, 0 after the break, and no other bit changes.
- Frames E0 75, then 75 with no prefix -> keystroke[4]=1 only; the bare 75 leaves keystroke unchanged.
- P make, P make (repeat), F0 4D, P make -> keystroke[9] goes 1, stays 1, stays 1, then goes 0.
- Make 55 three times -> exactly three 1-cycle pulses on keystroke[11], and keystroke[10] stays 0.
- Frame 0x1D sent with even parity -> one frame_err pulse and keystroke unchanged; the next valid 0x1D sets keystroke[0].
- 4 data bits followed by a 600 us gap, then a full 0x5A frame -> no frame_err, and keystroke[12]=1 with the required latency; a following R make -> keystroke[8] pulses for 1 cycle, and keystroke[12] and keystroke[9] clear.
